// File: rtl/ila_dbg_pkg.sv
// rtl/ila_dbg_pkg.sv - shared types and helpers for the ILA probe scheduler
package ila_dbg_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_CAPTURE = 2'd2
   } ila_state_e;

   // Group-select width; never narrower than one bit so a 1-group build still elaborates.
   function automatic int grp_w(input int num_grp);
      return (num_grp <= 1) ? 1 : $clog2(num_grp);
   endfunction

endpackage

// File: rtl/ila_probe_mux.sv
// rtl/ila_probe_mux.sv - registered NUM_GRP:1 probe data multiplexer
module ila_probe_mux #(
   parameter int NUM_GRP = 4,
   parameter int DW      = 32,
   parameter int SEL_W   = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [SEL_W-1:0]      sel_i,
   input  logic [NUM_GRP*DW-1:0] din_i,
   output logic [DW-1:0]         dout_o
);

   logic [DW-1:0] sel_data;
   logic [DW-1:0] dout_q;

   // Pick the selected group's slice; unmatched selects fall back to zero.
   always_comb begin
      sel_data = '0;
      for (int g = 0; g < NUM_GRP; g++) begin
         if (sel_i == SEL_W'(g)) begin
            sel_data = din_i[g*DW +: DW];
         end
      end
   end

   // Register the mux so the ILA probe sees a clean, glitch-free bus.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dout_q <= '0;
      end else begin
         dout_q <= sel_data;
      end
   end

   assign dout_o = dout_q;

endmodule

// File: rtl/ila_probe_sched.sv
// rtl/ila_probe_sched.sv - schedules NUM_GRP debug groups onto one ILA probe port
module ila_probe_sched
   import ila_dbg_pkg::*;
#(
   parameter int NUM_GRP = 4,
   parameter int DW      = 32,
   parameter int CNT_W   = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_GRP*DW-1:0]      grp_data,
   input  logic [NUM_GRP-1:0]         grp_trig,
   input  logic                       cfg_arm,
   input  logic                       cfg_abort,
   input  logic                       cfg_rotate,
   input  logic [$clog2(NUM_GRP)-1:0] cfg_grp,
   input  logic [CNT_W-1:0]           cfg_post,
   (* syn_keep = 1 *) output logic [DW-1:0]              probe_data,
   (* syn_keep = 1 *) output logic                       probe_trig,
   (* syn_keep = 1 *) output logic [$clog2(NUM_GRP)-1:0] probe_grp,
   (* syn_keep = 1 *) output logic                       busy,
   (* syn_keep = 1 *) output logic                       done
);

   localparam int GRP_W = grp_w(NUM_GRP);

   ila_state_e       state_q,  state_d;
   logic [GRP_W-1:0] cur_q,    cur_d;
   logic [CNT_W-1:0] cnt_q,    cnt_d;
   logic [CNT_W-1:0] post_q,   post_d;
   logic             rotate_q, rotate_d;
   logic [GRP_W:0]   visit_q,  visit_d;
   logic             trig_q,   trig_d;
   logic             done_q,   done_d;
   logic [GRP_W-1:0] pgrp_q,   pgrp_d;
   logic [GRP_W:0]   visit_inc;

   // State and latched configuration registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cur_q    <= '0;
         cnt_q    <= '0;
         post_q   <= '0;
         rotate_q <= 1'b0;
         visit_q  <= '0;
         trig_q   <= 1'b0;
         done_q   <= 1'b0;
         pgrp_q   <= '0;
      end else begin
         state_q  <= state_d;
         cur_q    <= cur_d;
         cnt_q    <= cnt_d;
         post_q   <= post_d;
         rotate_q <= rotate_d;
         visit_q  <= visit_d;
         trig_q   <= trig_d;
         done_q   <= done_d;
         pgrp_q   <= pgrp_d;
      end
   end

   assign visit_inc = visit_q + 1'b1;

   // Next-state logic: abort overrides everything, arm only in IDLE, cur moves only on
   // arm accept or rotate advance.
   always_comb begin
      state_d  = state_q;
      cur_d    = cur_q;
      cnt_d    = cnt_q;
      post_d   = post_q;
      rotate_d = rotate_q;
      visit_d  = visit_q;
      trig_d   = 1'b0;
      done_d   = 1'b0;
      pgrp_d   = cur_q;
      if (cfg_abort) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (cfg_arm) begin
                  state_d  = ST_ARMED;
                  cur_d    = (32'(cfg_grp) >= NUM_GRP) ? '0 : GRP_W'(cfg_grp);
                  post_d   = cfg_post;
                  rotate_d = cfg_rotate;
                  visit_d  = '0;
               end
            end
            ST_ARMED: begin
               if (grp_trig[cur_q]) begin
                  state_d = ST_CAPTURE;
                  cnt_d   = post_q;
                  trig_d  = 1'b1;
               end
            end
            ST_CAPTURE: begin
               if (cnt_q == '0) begin
                  visit_d = visit_inc;
                  if (rotate_q && (32'(visit_inc) < NUM_GRP)) begin
                     state_d = ST_ARMED;
                     cur_d   = (32'(cur_q) == NUM_GRP - 1) ? '0 : cur_q + 1'b1;
                  end else begin
                     state_d = ST_IDLE;
                     done_d  = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   ila_probe_mux #(
      .NUM_GRP (NUM_GRP),
      .DW      (DW),
      .SEL_W   (GRP_W)
   ) u_mux (
      .clk    (clk),
      .rst_n  (rst_n),
      .sel_i  (cur_q),
      .din_i  (grp_data),
      .dout_o (probe_data)
   );

   assign probe_trig = trig_q;
   assign probe_grp  = pgrp_q;
   assign busy       = (state_q != ST_IDLE);
   assign done       = done_q;

endmodule

// File: tb/tb_ila_probe_sched.sv
// tb/tb_ila_probe_sched.sv - directed self-checking bench for ila_probe_sched
module tb_ila_probe_sched;

   localparam int NUM_GRP = 4;
   localparam int DW      = 32;
   localparam int CNT_W   = 16;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [NUM_GRP*DW-1:0] grp_data;
   logic [NUM_GRP-1:0]    grp_trig;
   logic                  cfg_arm;
   logic                  cfg_abort;
   logic                  cfg_rotate;
   logic [1:0]            cfg_grp;
   logic [CNT_W-1:0]      cfg_post;
   logic [DW-1:0]         probe_data;
   logic                  probe_trig;
   logic [1:0]            probe_grp;
   logic                  busy;
   logic                  done;

   int n_checks = 0;
   int n_fail   = 0;

   ila_probe_sched #(
      .NUM_GRP (NUM_GRP),
      .DW      (DW),
      .CNT_W   (CNT_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .grp_data   (grp_data),
      .grp_trig   (grp_trig),
      .cfg_arm    (cfg_arm),
      .cfg_abort  (cfg_abort),
      .cfg_rotate (cfg_rotate),
      .cfg_grp    (cfg_grp),
      .cfg_post   (cfg_post),
      .probe_data (probe_data),
      .probe_trig (probe_trig),
      .probe_grp  (probe_grp),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] gdata(input int g);
      return 32'hA5A5_0000 + 32'(g * 17 + 3);
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   int trig_cnt;
   int done_cnt;
   logic [1:0] seq [4];

   initial begin
      for (int g = 0; g < NUM_GRP; g++) grp_data[g*DW +: DW] = gdata(g);
      rst_n      = 1'b0;
      grp_trig   = 4'hF;
      cfg_arm    = 1'b0;
      cfg_abort  = 1'b0;
      cfg_rotate = 1'b0;
      cfg_grp    = 2'd0;
      cfg_post   = '0;

      // 1: reset held 3 cycles with all triggers high
      repeat (3) tick();
      check("rst_probe_data", probe_data, 32'h0);
      check("rst_probe_trig", probe_trig, 32'h0);
      check("rst_probe_grp",  probe_grp,  32'h0);
      check("rst_busy",       busy,       32'h0);
      check("rst_done",       done,       32'h0);
      grp_trig = 4'h0;
      rst_n    = 1'b1;
      tick();
      check("rel_probe_trig", probe_trig, 32'h0);
      check("rel_done",       done,       32'h0);

      // 2: SINGLE on group 2, post=5
      cfg_grp = 2'd2; cfg_post = 16'd5; cfg_rotate = 1'b0; cfg_arm = 1'b1;
      tick();
      cfg_arm = 1'b0;
      check("s_busy_armed", busy, 32'h1);
      tick();
      check("s_probe_grp", probe_grp, 32'h2);
      check("s_probe_data", probe_data, gdata(2));
      repeat (8) tick();
      check("s_no_trig_yet", probe_trig, 32'h0);
      grp_trig = 4'b0100;
      tick();
      check("s_probe_trig", probe_trig, 32'h1);
      grp_trig = 4'h0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("s_trig_1cyc", probe_trig, 32'h0);
         check("s_no_done",   done,       32'h0);
         check("s_grp_hold",  probe_grp,  32'h2);
      end
      tick();
      check("s_done", done, 32'h1);
      check("s_busy_end", busy, 32'h0);
      tick();
      check("s_done_pulse", done, 32'h0);

      // 3: ROTATE from group 3, post=0, triggers held
      cfg_grp = 2'd3; cfg_post = 16'd0; cfg_rotate = 1'b1; cfg_arm = 1'b1;
      grp_trig = 4'hF;
      tick();
      cfg_arm = 1'b0;
      trig_cnt = 0;
      done_cnt = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (probe_trig) begin
            if (trig_cnt < 4) seq[trig_cnt] = probe_grp;
            trig_cnt++;
         end
         if (done) done_cnt++;
      end
      check("r_trig_count", trig_cnt, 32'd4);
      check("r_done_count", done_cnt, 32'd1);
      check("r_seq0", seq[0], 32'd3);
      check("r_seq1", seq[1], 32'd0);
      check("r_seq2", seq[2], 32'd1);
      check("r_seq3", seq[3], 32'd2);
      check("r_busy_end", busy, 32'h0);
      grp_trig = 4'h0;
      cfg_rotate = 1'b0;

      // 4: abort at cnt=3 together with arm
      cfg_grp = 2'd1; cfg_post = 16'd5; cfg_arm = 1'b1; grp_trig = 4'b0010;
      tick();
      cfg_arm = 1'b0;
      tick();
      grp_trig = 4'h0;
      check("a_trig", probe_trig, 32'h1);
      repeat (2) tick();
      cfg_abort = 1'b1; cfg_arm = 1'b1; cfg_grp = 2'd0;
      tick();
      cfg_abort = 1'b0; cfg_arm = 1'b0;
      check("a_busy", busy, 32'h0);
      check("a_done", done, 32'h0);
      check("a_trig_off", probe_trig, 32'h0);
      repeat (3) begin
         tick();
         check("a_stay_idle", busy, 32'h0);
         check("a_no_done",   done, 32'h0);
      end
      check("a_grp_kept", probe_grp, 32'h1);

      // 5: non-selected trigger while ARMED on group 0
      cfg_grp = 2'd0; cfg_post = 16'd2; cfg_arm = 1'b1;
      tick();
      cfg_arm = 1'b0;
      grp_trig = 4'b0010;
      tick();
      grp_trig = 4'h0;
      check("n_busy", busy, 32'h1);
      tick();
      check("n_no_trig", probe_trig, 32'h0);
      check("n_still_armed", busy, 32'h1);
      cfg_abort = 1'b1;
      tick();
      cfg_abort = 1'b0;
      check("n_abort_idle", busy, 32'h0);

      // 6: reset mid-CAPTURE, then a fresh arm
      cfg_grp = 2'd3; cfg_post = 16'd10; cfg_arm = 1'b1; grp_trig = 4'b1000;
      tick();
      cfg_arm = 1'b0;
      repeat (2) tick();
      grp_trig = 4'h0;
      check("m_busy_cap", busy, 32'h1);
      rst_n = 1'b0;
      tick();
      check("m_rst_busy", busy, 32'h0);
      check("m_rst_grp",  probe_grp, 32'h0);
      check("m_rst_data", probe_data, 32'h0);
      check("m_rst_trig", probe_trig, 32'h0);
      rst_n = 1'b1;
      tick();
      check("m_rel_done", done, 32'h0);
      cfg_grp = 2'd1; cfg_post = 16'd1; cfg_arm = 1'b1; grp_trig = 4'b0010;
      tick();
      cfg_arm = 1'b0;
      tick();
      grp_trig = 4'h0;
      check("m_trig", probe_trig, 32'h1);
      tick();
      check("m_no_done", done, 32'h0);
      tick();
      check("m_done", done, 32'h1);
      check("m_grp", probe_grp, 32'h1);
      check("m_data", probe_data, gdata(1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
